// File: rtl/cursor_select_ctrl.sv
// -----------------------------------------------------------------------------
// cursor_select_ctrl
//
// Turns five raw push buttons into a 3x3 board cursor for the pixel mapper and
// hands a chosen free cell to the game-logic FSM.
//
// Ports:
//   clk, rst_n         system clock, asynchronous active-low reset
//   btn_up/down/left/right/sel  raw active-high buttons, asynchronous to clk
//   turn_active        high while the local player may choose a cell
//   board_occ[8:0]     bit i set = cell i already occupied
//   player_pos[3:0]    cursor cell 0..8, row-major (row = pos/3, col = pos%3)
//   player_enable      cursor visible; blinks while selecting
//   place_valid        placement request pending
//   place_pos[3:0]     requested cell, stable while place_valid is high
//   place_ready        game logic accepts the request
//   sel_reject         one-cycle pulse when select hits an occupied cell
//
// Handshake: place_valid rises with place_pos and both hold until the first
// clock edge that sees place_valid && place_ready; place_valid is low on the
// following cycle. place_ready may already be high when place_valid rises.
// Only an asynchronous reset withdraws a pending request.
// -----------------------------------------------------------------------------
module cursor_select_ctrl #(
    parameter int DEB_CYCLES = 250000,
    parameter int BLINK_DIV  = 6250000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_sel,
    input  logic       turn_active,
    input  logic [8:0] board_occ,
    output logic [3:0] player_pos,
    output logic       player_enable,
    output logic       place_valid,
    output logic [3:0] place_pos,
    input  logic       place_ready,
    output logic       sel_reject
);

    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int BW = $clog2(BLINK_DIV + 1);
    localparam logic [DW-1:0] DEB_LAST   = DW'(DEB_CYCLES - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SELECT = 2'd1,
        PLACE  = 2'd2
    } state_t;

    state_t state, state_d;

    // Button vector order: 0 sel, 1 up, 2 down, 3 left, 4 right.
    logic [4:0] raw, sync1, sync2, deb, deb_d, press;
    assign raw = {btn_right, btn_left, btn_down, btn_up, btn_sel};

    // Synchronizer plus registered rising-edge detect on the debounced level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            deb_d <= '0;
            press <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            deb_d <= deb;
            press <= deb & ~deb_d;
        end
    end

    // The level follows the synced input only after DEB_CYCLES consecutive
    // differing samples; agreeing with it again restarts the count.
    for (genvar i = 0; i < 5; i++) begin : g_deb
        logic [DW-1:0] cnt;
        logic          level;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt   <= '0;
                level <= 1'b0;
            end else if (sync2[i] == level) begin
                cnt <= '0;
            end else if (cnt == DEB_LAST) begin
                cnt   <= '0;
                level <= sync2[i];
            end else begin
                cnt <= cnt + DW'(1);
            end
        end
        assign deb[i] = level;
    end

    // One action per cycle: sel > up > down > left > right.
    logic act_sel, act_up, act_down, act_left, act_right, act_move;
    assign act_sel   = press[0];
    assign act_up    = press[1] & ~press[0];
    assign act_down  = press[2] & ~|press[1:0];
    assign act_left  = press[3] & ~|press[2:0];
    assign act_right = press[4] & ~|press[3:0];
    assign act_move  = act_up | act_down | act_left | act_right;

    logic [1:0] col;
    always_comb begin
        case (player_pos)
            4'd0, 4'd3, 4'd6: col = 2'd0;
            4'd1, 4'd4, 4'd7: col = 2'd1;
            default:          col = 2'd2;
        endcase
    end

    logic [BW-1:0] blink_cnt, blink_d;
    logic [3:0]    pos_d, ppos_d;
    logic          en_d, valid_d, rej_d;

    always_comb begin
        state_d = state;
        pos_d   = player_pos;
        en_d    = player_enable;
        blink_d = blink_cnt;
        valid_d = place_valid;
        ppos_d  = place_pos;
        rej_d   = 1'b0;
        case (state)
            IDLE: begin
                en_d = 1'b0;
                if (turn_active) begin
                    state_d = SELECT;
                    en_d    = 1'b1;
                    blink_d = '0;
                end
            end
            SELECT: begin
                if (blink_cnt == BLINK_LAST) begin
                    blink_d = '0;
                    en_d    = ~player_enable;
                end else begin
                    blink_d = blink_cnt + BW'(1);
                end
                if (!turn_active) begin
                    state_d = IDLE;
                    en_d    = 1'b0;
                end else if (act_sel) begin
                    if (board_occ[player_pos]) begin
                        rej_d = 1'b1;
                    end else begin
                        state_d = PLACE;
                        valid_d = 1'b1;
                        ppos_d  = player_pos;
                        en_d    = 1'b1;
                    end
                end else if (act_move) begin
                    // A moved cursor is shown immediately and gets a full
                    // visible half-period.
                    en_d    = 1'b1;
                    blink_d = '0;
                    if (act_up) begin
                        pos_d = (player_pos >= 4'd3) ? player_pos - 4'd3 : player_pos + 4'd6;
                    end else if (act_down) begin
                        pos_d = (player_pos <= 4'd5) ? player_pos + 4'd3 : player_pos - 4'd6;
                    end else if (act_left) begin
                        pos_d = (col == 2'd0) ? player_pos + 4'd2 : player_pos - 4'd1;
                    end else begin
                        pos_d = (col == 2'd2) ? player_pos - 4'd2 : player_pos + 4'd1;
                    end
                end
            end
            PLACE: begin
                // turn_active is deliberately ignored: the request stays
                // until the game logic takes it.
                en_d = 1'b1;
                if (place_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                    en_d    = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                en_d    = 1'b0;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            player_pos    <= 4'd4;
            player_enable <= 1'b0;
            blink_cnt     <= '0;
            place_valid   <= 1'b0;
            place_pos     <= 4'd0;
            sel_reject    <= 1'b0;
        end else begin
            state         <= state_d;
            player_pos    <= pos_d;
            player_enable <= en_d;
            blink_cnt     <= blink_d;
            place_valid   <= valid_d;
            place_pos     <= ppos_d;
            sel_reject    <= rej_d;
        end
    end

endmodule

// File: tb/tb_cursor_select_ctrl.sv
module tb_cursor_select_ctrl;

    localparam int DEB   = 4;
    localparam int BLINK = 8;
    localparam int B_SEL   = 0;
    localparam int B_UP    = 1;
    localparam int B_DOWN  = 2;
    localparam int B_LEFT  = 3;
    localparam int B_RIGHT = 4;

    // ---------------- clock / reset / DUT ----------------
    logic       clk         = 1'b0;
    logic       rst_n       = 1'b1;
    logic       btn_up      = 1'b0;
    logic       btn_down    = 1'b0;
    logic       btn_left    = 1'b0;
    logic       btn_right   = 1'b0;
    logic       btn_sel     = 1'b0;
    logic       turn_active = 1'b0;
    logic [8:0] board_occ   = '0;
    logic       place_ready = 1'b0;
    logic [3:0] player_pos;
    logic       player_enable;
    logic       place_valid;
    logic [3:0] place_pos;
    logic       sel_reject;

    cursor_select_ctrl #(
        .DEB_CYCLES(DEB),
        .BLINK_DIV (BLINK)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn_up       (btn_up),
        .btn_down     (btn_down),
        .btn_left     (btn_left),
        .btn_right    (btn_right),
        .btn_sel      (btn_sel),
        .turn_active  (turn_active),
        .board_occ    (board_occ),
        .player_pos   (player_pos),
        .player_enable(player_enable),
        .place_valid  (place_valid),
        .place_pos    (place_pos),
        .place_ready  (place_ready),
        .sel_reject   (sel_reject)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard / reference model ----------------
    int         checks     = 0;
    int         errors     = 0;
    int         cyc        = 0;
    int         reload_cyc = 0;
    int         reload_at  = -1;
    bit         blink_chk  = 1'b0;
    int         m_pos      = 4;
    logic [3:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Cursor visible for BLINK cycles after each reload, then alternating.
    function automatic logic blink_model();
        return (((cyc - reload_cyc) / BLINK) % 2) == 0;
    endfunction

    // Board move computed on row/column coordinates with wrap-around.
    function automatic int move(input int p, input int b);
        int r;
        int c;
        r = p / 3;
        c = p % 3;
        case (b)
            B_UP:    r = (r + 2) % 3;
            B_DOWN:  r = (r + 1) % 3;
            B_LEFT:  c = (c + 2) % 3;
            default: c = (c + 1) % 3;
        endcase
        return r * 3 + c;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (cyc == reload_at) reload_cyc = cyc;
        if (blink_chk) check("blink", player_enable, blink_model());
    endtask

    task automatic set_btn(input int b, input logic v);
        case (b)
            B_SEL:   btn_sel   = v;
            B_UP:    btn_up    = v;
            B_DOWN:  btn_down  = v;
            B_LEFT:  btn_left  = v;
            default: btn_right = v;
        endcase
    endtask

    // Clean press of a move button; the cursor must change exactly DEB+4
    // edges after the raw edge (pulse at DEB+3, move one cycle later).
    task automatic press_move(input int b);
        logic [3:0] exp_pos;
        int         old;
        exp_pos = exp_q.pop_front();
        old     = m_pos;
        set_btn(b, 1'b1);
        reload_at = cyc + DEB + 4;
        for (int k = 1; k <= DEB + 6; k++) begin
            tick();
            if (k < DEB + 4) check("move_early", player_pos, old);
            else             check("move_pos", player_pos, exp_pos);
        end
        set_btn(b, 1'b0);
        for (int k = 0; k < DEB + 6; k++) begin
            tick();
            check("move_keep", player_pos, exp_pos);
        end
        m_pos = exp_pos;
    endtask

    // Select press; covers reject and the full placement handshake.
    task automatic press_sel(input int hold, input bit early, input bit with_up,
                             input bit btn_in_hold, input bit drop_turn);
        logic occ;
        occ       = board_occ[m_pos];
        blink_chk = 1'b0;
        if (early) place_ready = 1'b1;
        btn_sel = 1'b1;
        if (with_up) btn_up = 1'b1;
        for (int k = 1; k <= DEB + 4; k++) begin
            tick();
            check("sel_valid", place_valid, (k == DEB + 4) && !occ);
            check("sel_reject", sel_reject, (k == DEB + 4) && occ);
            check("sel_nomove", player_pos, m_pos);
        end
        btn_sel = 1'b0;
        btn_up  = 1'b0;
        if (occ) begin
            place_ready = 1'b0;
            blink_chk   = 1'b1;
            for (int k = 0; k < DEB + 6; k++) begin
                tick();
                check("reject_once", sel_reject, 1'b0);
                check("reject_noreq", place_valid, 1'b0);
            end
        end else begin
            check("req_pos", place_pos, m_pos);
            check("place_en", player_enable, 1'b1);
            if (drop_turn) turn_active = 1'b0;
            if (btn_in_hold) btn_up = 1'b1;
            for (int k = 0; k < hold; k++) begin
                tick();
                check("hold_valid", place_valid, 1'b1);
                check("hold_pos", place_pos, m_pos);
                check("hold_en", player_enable, 1'b1);
                check("hold_cursor", player_pos, m_pos);
            end
            btn_up      = 1'b0;
            place_ready = 1'b1;
            tick();
            check("done_valid", place_valid, 1'b0);
            check("done_en", player_enable, 1'b0);
            place_ready = 1'b0;
            if (drop_turn) begin
                tick();
                check("idle_en", player_enable, 1'b0);
                check("idle_valid", place_valid, 1'b0);
                turn_active = 1'b1;
            end
            tick();
            check("reenter_en", player_enable, 1'b1);
            reload_cyc = cyc;
            blink_chk  = 1'b1;
            for (int k = 0; k < DEB + 6; k++) begin
                tick();
                check("after_pos", player_pos, m_pos);
                check("after_valid", place_valid, 1'b0);
            end
        end
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int b;
        bit early;
        int hold;

        // reset
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_pos", player_pos, 4'd4);
        check("rst_en", player_enable, 1'b0);
        check("rst_valid", place_valid, 1'b0);
        check("rst_ppos", place_pos, 4'd0);
        check("rst_reject", sel_reject, 1'b0);
        rst_n = 1'b1;

        // 1: turn starts, cursor at centre, blinking
        turn_active = 1'b1;
        tick();
        check("enter_en", player_enable, 1'b1);
        check("enter_pos", player_pos, 4'd4);
        reload_cyc = cyc;
        blink_chk  = 1'b1;
        repeat (20) tick();

        // 2: clean presses with wrap-around
        exp_q.push_back(4'd5); exp_q.push_back(4'd3); exp_q.push_back(4'd6);
        exp_q.push_back(4'd3); exp_q.push_back(4'd0); exp_q.push_back(4'd2);
        press_move(B_RIGHT);
        press_move(B_RIGHT);
        press_move(B_DOWN);
        press_move(B_UP);
        press_move(B_UP);
        press_move(B_LEFT);

        // 3: bouncing left button, then a stable press gives one move
        for (int i = 0; i < 20; i++) begin
            btn_left = ((i / 2) % 2) == 0;
            tick();
            check("bounce_nomove", player_pos, m_pos);
        end
        exp_q.push_back(4'(move(m_pos, B_LEFT)));
        press_move(B_LEFT);

        // 4: reject on occupied centre, then place on 5 with a slow ready
        exp_q.push_back(4'(move(m_pos, B_DOWN)));
        press_move(B_DOWN);
        board_occ = 9'b000010000;
        press_sel(0, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_q.push_back(4'(move(m_pos, B_RIGHT)));
        press_move(B_RIGHT);
        press_sel(10, 1'b0, 1'b0, 1'b1, 1'b0);

        // 5: sel beats up in the same cycle; turn drops during PLACE
        exp_q.push_back(4'(move(m_pos, B_UP)));
        press_move(B_UP);
        exp_q.push_back(4'(move(m_pos, B_LEFT)));
        press_move(B_LEFT);
        press_sel(5, 1'b0, 1'b1, 1'b0, 1'b1);

        // 6: asynchronous reset in the middle of PLACE
        board_occ = '0;
        blink_chk = 1'b0;
        btn_sel   = 1'b1;
        repeat (DEB + 4) tick();
        check("p6_valid", place_valid, 1'b1);
        check("p6_ppos", place_pos, m_pos);
        btn_sel = 1'b0;
        repeat (2) tick();
        check("p6_held", place_valid, 1'b1);
        #3 rst_n = 1'b0;
        #1;
        check("arst_valid", place_valid, 1'b0);
        check("arst_pos", player_pos, 4'd4);
        check("arst_en", player_enable, 1'b0);
        check("arst_ppos", place_pos, 4'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        m_pos = 4;
        tick();
        check("rerun_en", player_enable, 1'b1);
        reload_cyc = cyc;
        blink_chk  = 1'b1;

        // random moves and selections against the model
        repeat (12) begin
            b = $urandom_range(B_UP, B_RIGHT);
            exp_q.push_back(4'(move(m_pos, b)));
            press_move(b);
        end
        repeat (6) begin
            board_occ = 9'($urandom_range(0, 511));
            early     = bit'($urandom_range(0, 1));
            hold      = early ? 0 : $urandom_range(0, 6);
            press_sel(hold, early, 1'b0, 1'b0, 1'b0);
            b = $urandom_range(B_UP, B_RIGHT);
            exp_q.push_back(4'(move(m_pos, b)));
            press_move(b);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
